traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising-edge) and rst_n.
REQ-002 Parameter GREEN_TICKS SHALL default to 20 and set the minimum green duration in ticks (1..255).
REQ-003 Parameter YELLOW_TICKS SHALL default to 4 and set the yellow duration in ticks (1..255).
REQ-004 Parameter ALLRED_TICKS SHALL default to 2 and set the all-red clearance duration in ticks (1..255).
REQ-005 Parameter WALK_TICKS SHALL default to 10 and set the pedestrian walk duration in ticks (1..255).
REQ-006 The ports SHALL be exactly:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- tick_en  in  1  timebase strobe; one tick per high cycle.
- car_ns  in  1  north-south vehicle demand, level.
- car_ew  in  1  east-west vehicle demand, level.
- ped_req  in  1  pedestrian button, pulse or level.
- ns_light  out  3  one-hot {R,Y,G}, NS approach.
- ew_light  out  3  one-hot {R,Y,G}, EW approach.
- walk  out  1  pedestrian walk lamp.
- state  out  3  current state code, for debug.

Function
REQ-007 The state machine SHALL have six states: ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, WALK.
REQ-008 An 8-bit timer SHALL clear to 0 on every state change and increment on tick_en; it SHALL saturate at DUR-1, where DUR is the duration of the current state.
REQ-009 "Expired" SHALL mean timer==DUR-1 and tick_en==1; the state SHALL change on that same clock edge.
REQ-010 The ALL_RED state SHALL exit on expiry:
- to WALK if ped_pending==1;
- otherwise to NS_GREEN if next_dir==NS, or to EW_GREEN if next_dir==EW.
REQ-011 The WALK state SHALL exit on expiry to the green selected by next_dir.
REQ-012 The NS_GREEN and EW_GREEN states SHALL move to their yellow state only when minimum green has expired (or timer is saturated with tick_en high) and (cross-road demand==1 or ped_pending==1); otherwise green SHALL hold indefinitely.
REQ-013 The NS_YELLOW and EW_YELLOW states SHALL exit on expiry to ALL_RED, setting next_dir to the opposite road.
REQ-014 The ped_pending flag SHALL set on any cycle with ped_req==1 and clear on the edge entering WALK; clear SHALL win on that edge, and ped_req seen during WALK SHALL re-latch.
REQ-015 Light outputs SHALL be registered and decoded from state:
- each green or yellow state lights only its road, with the other road red;
- ALL_RED and WALK drive both roads red;
- walk==1 only in WALK.
REQ-016 Exactly one bit of each light vector SHALL be high in every cycle, and no state SHALL show green or yellow on both roads.
REQ-017 Vehicle sensors SHALL be sampled directly, with no latching.

Reset
REQ-018 Asserting rst_n low SHALL immediately force: state=ALL_RED, timer=0, ped_pending=0, next_dir=NS, ns_light=ew_light=3'b100, walk=0.
REQ-019 Reset asserted mid-phase (including during yellow or WALK) SHALL abandon the phase with no completion.

Structure
REQ-020 The state enumeration, light encodings (RED=3'b100, YEL=3'b010, GRN=3'b001) and TIMER_W=8 SHALL reside in shared package traffic_pkg.
REQ-021 The timer (clear, enable, saturate, expiry compare) SHALL be one sub-module, tl_timer, instantiated once.

Verification
All scenarios below use GREEN=4, YELLOW=2, ALLRED=1, WALK=3, tick_en=1 constantly.
REQ-022 Reset release: first edge gives NS_GREEN (ns_light=001, ew_light=100), which is held while car_ew=0 for 50 cycles.
REQ-023 Cross demand: set car_ew=1 at reset release.
- Expected sequence: NS_GREEN 4 cycles, NS_YELLOW 2, ALL_RED 1, then EW_GREEN.
- EW_GREEN holds while car_ns=0.
REQ-024 Pedestrian request: one-cycle ped_req pulse during NS_GREEN.
- Expected sequence: NS_YELLOW, then ALL_RED, then WALK for 3 cycles with walk=1 and both roads 100, then EW_GREEN.
- ped_pending==0 after WALK entry.
REQ-025 ped_req held high across WALK entry: a second WALK occurs at the next ALL_RED.
REQ-026 tick_en asserted every 3rd cycle: the duration of every phase is tripled, measured in clk cycles.
REQ-027 rst_n dropped for 1 cycle mid-EW_YELLOW: outputs go to 100/100 asynchronously; after release, the sequence restarts as in REQ-022.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller: state codes, lamp encodings,
// timer width and the state-to-lamp decode.
package traffic_pkg;

  localparam int TIMER_W = 8;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    WALK      = 3'd5
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  // Any state not explicitly lit falls back to both roads red.
  function automatic lamps_t decode_lamps(state_t s);
    lamps_t l;
    l = '{ns: RED, ew: RED, walk: 1'b0};
    case (s)
      NS_GREEN:  l.ns   = GRN;
      NS_YELLOW: l.ns   = YEL;
      EW_GREEN:  l.ew   = GRN;
      EW_YELLOW: l.ew   = YEL;
      WALK:      l.walk = 1'b1;
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Phase timer: clears on a state change, counts ticks and holds at dur-1;
// expired flags the tick that completes the phase.
module tl_timer
  import traffic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               tick_en,
  input  logic [TIMER_W-1:0] dur,
  output logic               expired
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] last;

  assign last    = dur - TIMER_W'(1);
  assign expired = tick_en && (count == last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick_en && (count != last)) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with demand-actuated greens, all-red
// clearance and a pedestrian walk phase served between greens.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state
);

  state_t             cur;
  state_t             nxt;
  dir_t               next_dir;
  logic               ped_pending;
  logic [TIMER_W-1:0] dur;
  logic               expired;
  logic               advance;
  lamps_t             lamps_nxt;

  function automatic state_t green_of(dir_t d);
    return (d == DIR_EW) ? EW_GREEN : NS_GREEN;
  endfunction

  always_comb begin
    case (cur)
      NS_GREEN, EW_GREEN:   dur = TIMER_W'(GREEN_TICKS);
      NS_YELLOW, EW_YELLOW: dur = TIMER_W'(YELLOW_TICKS);
      WALK:                 dur = TIMER_W'(WALK_TICKS);
      default:              dur = TIMER_W'(ALLRED_TICKS);
    endcase
  end

  // NOTE: nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt = cur;
    case (cur)
      ALL_RED:   if (expired) nxt = ped_pending ? WALK : green_of(next_dir);
      WALK:      if (expired) nxt = green_of(next_dir);
      NS_GREEN:  if (expired && (car_ew || ped_pending)) nxt = NS_YELLOW;
      EW_GREEN:  if (expired && (car_ns || ped_pending)) nxt = EW_YELLOW;
      NS_YELLOW: if (expired) nxt = ALL_RED;
      EW_YELLOW: if (expired) nxt = ALL_RED;
      default:   nxt = ALL_RED;
    endcase
  end

  // No state loops to itself, so any difference is a phase change.
  assign advance   = (nxt != cur);
  assign lamps_nxt = decode_lamps(nxt);
  assign state     = cur;

  tl_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (advance),
    .tick_en (tick_en),
    .dur     (dur),
    .expired (expired)
  );

  // Lamps are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= ALL_RED;
      next_dir    <= DIR_NS;
      ped_pending <= 1'b0;
      ns_light    <= RED;
      ew_light    <= RED;
      walk        <= 1'b0;
    end else begin
      cur      <= nxt;
      ns_light <= lamps_nxt.ns;
      ew_light <= lamps_nxt.ew;
      walk     <= lamps_nxt.walk;
      if (advance && (cur == NS_YELLOW)) next_dir <= DIR_EW;
      if (advance && (cur == EW_YELLOW)) next_dir <= DIR_NS;
      // Entering WALK serves the request; a press on that edge is dropped.
      ped_pending <= (advance && (nxt == WALK)) ? 1'b0 : (ped_pending | ped_req);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench: a countdown-style phase model runs alongside the DUT
// and is compared every cycle; directed scenarios pin exact phase lengths.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int WK = 3;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tick_en = 1'b1;
  logic       car_ns  = 1'b0;
  logic       car_ew  = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_mode = 0;  // 0: always, 1: every third cycle, 2: random
  int tick_cnt  = 0;

  traffic_light_ctrl #(
    .GREEN_TICKS  (G),
    .YELLOW_TICKS (Y),
    .ALLRED_TICKS (AR),
    .WALK_TICKS   (WK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_en  (tick_en),
    .car_ns   (car_ns),
    .car_ew   (car_ew),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dur_of(state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return G;
      NS_YELLOW, EW_YELLOW: return Y;
      WALK:                 return WK;
      default:              return AR;
    endcase
  endfunction

  // {ns_light, ew_light, walk}
  function automatic logic [6:0] lamps_of(state_t s);
    case (s)
      NS_GREEN:  return 7'b001_100_0;
      NS_YELLOW: return 7'b010_100_0;
      EW_GREEN:  return 7'b100_001_0;
      EW_YELLOW: return 7'b100_010_0;
      WALK:      return 7'b100_100_1;
      default:   return 7'b100_100_0;
    endcase
  endfunction

  // Model: current phase, ticks still needed to finish it, pending press,
  // and which road gets the next green.
  state_t m_phase  = ALL_RED;
  int     m_rem    = AR;
  bit     m_ped    = 1'b0;
  bit     m_dir_ew = 1'b0;
  state_t m_nxt;
  bit     m_go;

  task automatic model_reset();
    m_phase  = ALL_RED;
    m_rem    = AR;
    m_ped    = 1'b0;
    m_dir_ew = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_nxt = m_phase;
      m_go  = 1'b0;
      if (tick_en) begin
        if (m_rem == 1) begin
          case (m_phase)
            ALL_RED: begin
              m_go  = 1'b1;
              m_nxt = m_ped ? WALK : (m_dir_ew ? EW_GREEN : NS_GREEN);
            end
            WALK: begin
              m_go  = 1'b1;
              m_nxt = m_dir_ew ? EW_GREEN : NS_GREEN;
            end
            NS_GREEN:  if (car_ew || m_ped) begin m_go = 1'b1; m_nxt = NS_YELLOW; end
            EW_GREEN:  if (car_ns || m_ped) begin m_go = 1'b1; m_nxt = EW_YELLOW; end
            NS_YELLOW: begin m_go = 1'b1; m_nxt = ALL_RED; m_dir_ew = 1'b1; end
            EW_YELLOW: begin m_go = 1'b1; m_nxt = ALL_RED; m_dir_ew = 1'b0; end
            default:   ;
          endcase
        end else begin
          m_rem--;
        end
      end
      m_ped = (m_go && m_nxt == WALK) ? 1'b0 : (m_ped | ped_req);
      if (m_go) begin
        m_phase = m_nxt;
        m_rem   = dur_of(m_nxt);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check("model_state", state, m_phase);
    check("model_lamps", {ns_light, ew_light, walk}, lamps_of(m_phase));
  end

  always @(negedge clk) begin
    case (tick_mode)
      0:       tick_en = 1'b1;
      1:       tick_en = (tick_cnt % 3) == 0;
      default: tick_en = ($urandom % 4) != 0;
    endcase
    tick_cnt++;
  end

  task automatic expect_phase(input string name, input state_t s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, "_state"}, state, s);
      check({name, "_lamps"}, {ns_light, ew_light, walk}, lamps_of(s));
    end
  endtask

  task automatic wait_state(input state_t s, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (state !== s && k < budget);
    check("wait_state", state, s);
  endtask

  task automatic do_reset(input int cycles);
    #2 rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release, no cross demand: NS green holds.
    do_reset(2);
    expect_phase("rel", ALL_RED, 1);
    expect_phase("ns_hold", NS_GREEN, 50);

    // Cross demand from release.
    car_ew = 1'b1;
    do_reset(2);
    expect_phase("x_rel", ALL_RED, 1);
    expect_phase("x_nsg", NS_GREEN, G);
    expect_phase("x_nsy", NS_YELLOW, Y);
    expect_phase("x_ar", ALL_RED, AR);
    expect_phase("x_ewg", EW_GREEN, 20);

    // One-cycle pedestrian pulse during NS green.
    car_ew = 1'b0;
    do_reset(2);
    expect_phase("p_rel", ALL_RED, 1);
    expect_phase("p_nsg", NS_GREEN, 1);
    ped_req = 1'b1;
    expect_phase("p_nsg", NS_GREEN, 1);
    ped_req = 1'b0;
    expect_phase("p_nsg", NS_GREEN, G - 2);
    expect_phase("p_nsy", NS_YELLOW, Y);
    expect_phase("p_ar", ALL_RED, AR);
    expect_phase("p_walk", WALK, 1);
    check("ped_cleared", dut.ped_pending, 1'b0);
    expect_phase("p_walk", WALK, WK - 1);
    expect_phase("p_ewg", EW_GREEN, 10);

    // Button held across WALK entry re-latches and earns a second walk.
    do_reset(2);
    expect_phase("h_rel", ALL_RED, 1);
    expect_phase("h_nsg", NS_GREEN, 1);
    ped_req = 1'b1;
    expect_phase("h_nsg", NS_GREEN, G - 1);
    expect_phase("h_nsy", NS_YELLOW, Y);
    expect_phase("h_ar", ALL_RED, AR);
    expect_phase("h_walk1", WALK, WK);
    ped_req = 1'b0;
    expect_phase("h_ewg", EW_GREEN, G);
    expect_phase("h_ewy", EW_YELLOW, Y);
    expect_phase("h_ar2", ALL_RED, AR);
    expect_phase("h_walk2", WALK, WK);
    expect_phase("h_nsg2", NS_GREEN, 10);

    // Tick every third cycle: phases entered on a tick last 3x as long.
    car_ew = 1'b1;
    car_ns = 1'b1;
    tick_mode = 1;
    do_reset(2);
    wait_state(NS_YELLOW, 100);
    expect_phase("t_nsy", NS_YELLOW, 3 * Y - 1);
    expect_phase("t_ar", ALL_RED, 3 * AR);
    expect_phase("t_ewg", EW_GREEN, 3 * G);
    expect_phase("t_ewy", EW_YELLOW, 3 * Y);
    expect_phase("t_ar2", ALL_RED, 3 * AR);
    expect_phase("t_nsg", NS_GREEN, 3 * G);

    // Reset pulse mid EW yellow: immediate all-red, then a clean restart.
    tick_mode = 0;
    do_reset(2);
    wait_state(EW_YELLOW, 60);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", state, ALL_RED);
    check("async_lamps", {ns_light, ew_light, walk}, 7'b100_100_0);
    car_ew = 1'b0;
    car_ns = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_phase("r_rel", ALL_RED, 1);
    expect_phase("r_nsg", NS_GREEN, 20);

    // Random traffic, ticks, presses and occasional resets.
    tick_mode = 2;
    repeat (3000) begin
      @(negedge clk);
      #2;
      car_ns  = ($urandom % 4) == 0;
      car_ew  = ($urandom % 4) == 0;
      ped_req = ($urandom % 16) == 0;
      rst_n   = ($urandom % 400) != 0;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
